// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sprite ROM arbiter with 2-cycle response pipeline; SPRITE_ARB_FIXED_PRIO_EN selects lowest-index-wins priority
module sprite_rom_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*10-1:0] req_addr,
  input  logic [NREQ*5-1:0] req_sel,
  output logic [NREQ-1:0]   gnt,
  output logic [9:0]        sprt_addr,
  output logic [4:0]        sprt_s,
  input  logic [2:0]        rom_data,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2:0]        rsp_data,
  output logic              rsp_err
);
  logic [9:0] addr_a [NREQ];
  logic [4:0] sel_a [NREQ];
  logic [IDW-1:0] win, p_id;
  logic found, accept, p_valid, p_err;
  for (genvar i = 0; i < NREQ; i++) begin : g_src
    assign addr_a[i] = req_addr[10*i +: 10];
    assign sel_a[i] = req_sel[5*i +: 5];
  end
`ifdef SPRITE_ARB_FIXED_PRIO_EN
  // lowest requesting index wins
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[k]) begin
        win = IDW'(k);
        found = 1'b1;
      end
  end
`else
  logic [IDW-1:0] last_id, idx;
  // search starts just after the last accepted requester
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_id) + k) % NREQ);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // remember the winner; idle cycles leave the pointer alone
  always_ff @(posedge Clk) begin
    if (Reset) last_id <= IDW'(NREQ - 1);
    else if (accept) last_id <= win;
  end
`endif
  assign accept = found && !Reset;
  assign gnt = accept ? NREQ'(1) << win : '0;
  // stage 1: present the winner's address/select to the ROM bank
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sprt_addr <= '0;
      sprt_s <= '0;
      p_valid <= 1'b0;
      p_id <= '0;
      p_err <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        sprt_addr <= addr_a[win];
        sprt_s <= sel_a[win];
        p_id <= win;
        p_err <= sel_a[win] > 5'd10;
      end
    end
  end
  // stage 2: capture ROM output, zeroing data for out-of-range selects
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= p_valid;
      rsp_err <= p_valid && p_err;
      if (p_valid) begin
        rsp_id <= p_id;
        rsp_data <= p_err ? 3'd0 : rom_data;
      end
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed stimulus with queued expected responses checked by an independent monitor
module tb_sprite_rom_arbiter;
  logic Clk = 1'b0, Reset = 1'b1;
  logic [3:0] req = '0, gnt;
  logic [39:0] req_addr;
  logic [19:0] req_sel;
  logic [9:0] sprt_addr;
  logic [4:0] sprt_s;
  logic [2:0] rom_data, rsp_data;
  logic rsp_valid, rsp_err;
  logic [1:0] rsp_id;
  logic [9:0] a_m [4];
  logic [4:0] s_m [4];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct { int cyc; logic [1:0] id; logic [2:0] data; logic err; } exp_t;
  exp_t q[$];

  sprite_rom_arbiter #(.NREQ(4), .IDW(2)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr), .req_sel(req_sel),
    .gnt(gnt), .sprt_addr(sprt_addr), .sprt_s(sprt_s), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  assign rom_data = sprt_addr[2:0] ^ sprt_s[2:0];
  assign req_addr = {a_m[3], a_m[2], a_m[1], a_m[0]};
  assign req_sel = {s_m[3], s_m[2], s_m[1], s_m[0]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] eg, input string nm);
    exp_t e;
    int id;
    @(negedge Clk);
    req = r;
    #1 chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    @(posedge Clk);
    #1;
    if (eg != 4'b0) begin
      id = 0;
      for (int i = 0; i < 4; i++) if (eg[i]) id = i;
      chk({nm, "_addr"}, 32'(sprt_addr), 32'(a_m[id]));
      chk({nm, "_sel"}, 32'(sprt_s), 32'(s_m[id]));
      e.cyc = cyc + 1;
      e.id = 2'(id);
      e.err = s_m[id] > 5'd10;
      e.data = e.err ? 3'd0 : a_m[id][2:0] ^ s_m[id][2:0];
      q.push_back(e);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 32'h0);
    chk({nm, "_outs"}, {13'b0, sprt_addr, sprt_s, rsp_valid, rsp_id, rsp_data, rsp_err}, 32'h0);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (rsp_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp: got id=%0d data=%0d at cycle %0d, expected no response", rsp_id, rsp_data, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.id !== rsp_id || e.data !== rsp_data || e.err !== rsp_err) begin
          n_bad++;
          $display("FAIL rsp: got cyc=%0d id=%0d data=%0d err=%0b expected cyc=%0d id=%0d data=%0d err=%0b",
                   cyc, rsp_id, rsp_data, rsp_err, e.cyc, e.id, e.data, e.err);
        end
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_rsp: got rsp_valid=0 at cycle %0d expected id=%0d", cyc, e.id);
    end
  end

  initial begin
    a_m[0] = 10'h05A; s_m[0] = 5'd3;
    a_m[1] = 10'h123; s_m[1] = 5'd7;
    a_m[2] = 10'h3FF; s_m[2] = 5'd15;
    a_m[3] = 10'h2C4; s_m[3] = 5'd10;
    req = 4'b1111;
    repeat (2) @(posedge Clk);
    #1 chk_zero("reset");
    @(negedge Clk);
    Reset = 1'b0;
    req = 4'b0;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    repeat (4) step(4'b1111, 4'b0001, "fixed_all");
`else
    for (int i = 0; i < 8; i++) step(4'b1111, 4'(1 << (i % 4)), "rr");
    step(4'b0000, 4'b0000, "idle");
    step(4'b1111, 4'b0001, "rr_wrap");
    step(4'b0000, 4'b0000, "idle_hold");
    step(4'b1111, 4'b0010, "rr_after_idle");
`endif
    step(4'b0001, 4'b0001, "single");
    step(4'b0100, 4'b0100, "bad_sel");
    step(4'b0000, 4'b0000, "drain");
    step(4'b0000, 4'b0000, "drain2");
    step(4'b0001, 4'b0001, "pre_reset");
    @(negedge Clk);
    Reset = 1'b1;
    req = 4'b1111;
    #1 q.delete();
    chk("reset_gnt_forced", 32'(gnt), 32'h0);
    @(posedge Clk);
    #1 chk_zero("mid_reset");
    @(negedge Clk);
    Reset = 1'b0;
    req = 4'b0;
    step(4'b1010, 4'b0010, "post_reset");
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    repeat (3) step(4'b0110, 4'b0010, "fixed_0110");
`else
    step(4'b1010, 4'b1000, "post_reset_rot");
    step(4'b0110, 4'b0010, "rr_0110_a");
    step(4'b0110, 4'b0100, "rr_0110_b");
    step(4'b0110, 4'b0010, "rr_0110_c");
`endif
    step(4'b0000, 4'b0000, "end_idle");
    repeat (4) @(negedge Clk);
    #1 chk("drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the sprite ROM bank (legal range 2..8).
REQ-002 SHALL have parameter IDW, default 2, requester-ID width; it SHALL equal clog2(NREQ).
REQ-003 SHALL have port Clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  NREQ  per-requester ROM-read request; req[i] belongs to requester i.
REQ-006 SHALL have port req_addr  input  NREQ*10  sprite pixel addresses; requester i at bits [10i+9:10i].
REQ-007 SHALL have port req_sel  input  NREQ*5  sprite ROM codes 0..10; requester i at bits [5i+4:5i].
REQ-008 SHALL have port gnt  output  NREQ  one-hot, combinational accept; transfer occurs on a rising edge where req[i] and gnt[i] are both high.
REQ-009 SHALL have port sprt_addr  output  10  registered address to the ROM bank.
REQ-010 SHALL have port sprt_s  output  5  registered ROM select to the ROM bank.
REQ-011 SHALL have port rom_data  input  3  palette code returned combinationally by the ROM bank.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle pulse marking a valid response.
REQ-013 SHALL have port rsp_id  output  IDW  requester index the response belongs to.
REQ-014 SHALL have port rsp_data  output  3  registered palette code.
REQ-015 SHALL have port rsp_err  output  1  high with rsp_valid when the accepted req_sel was greater than 10.

Function
REQ-016 SHALL assert at most one gnt bit per cycle, and only for a requester whose req is high.
REQ-017 SHALL arbitrate round-robin: the search starts at last_id+1 modulo NREQ, where last_id is the index of the last accepted requester.
REQ-018 SHALL, on an accept edge E0, register the winner's address and select into sprt_addr/sprt_s, set last_id to the winner, and capture the winner ID into the pipeline.
REQ-019 SHALL, on edge E1 (one cycle after E0), register rom_data into rsp_data, assert rsp_valid, and drive rsp_id with the captured ID.
REQ-020 SHALL therefore have a fixed 2-cycle latency from accept to response, and SHALL sustain one accept per cycle with no bubbles.
REQ-021 SHALL, for an accepted req_sel greater than 10, still issue the read, and SHALL force rsp_data to 0 with rsp_err=1.
REQ-022 SHALL hold sprt_addr/sprt_s at their previous values in cycles with no accept, and SHALL drive rsp_valid low one cycle later.
REQ-023 SHALL treat req as level-sensitive: a requester that keeps req high competes again on the next cycle, so back-to-back grants rotate among all active requesters.
REQ-024 SHALL leave last_id unchanged in cycles with no requests.

Reset
REQ-025 SHALL, while Reset is high, force gnt to 0 combinationally.
REQ-026 SHALL, while Reset is high, clear sprt_addr, sprt_s, rsp_valid, rsp_id, rsp_data, rsp_err and the pipeline valid.
REQ-027 SHALL, while Reset is high, set last_id to NREQ-1 so that requester 0 has first priority.
REQ-028 SHALL discard in-flight reads when Reset is asserted mid-operation: no rsp_valid in the cycle after Reset deasserts.

Configuration
REQ-029 SHALL provide macro SPRITE_ARB_FIXED_PRIO_EN; when it is defined, arbitration SHALL be fixed priority with the lowest index winning, and last_id SHALL be unused.
REQ-030 SHALL, when SPRITE_ARB_FIXED_PRIO_EN is not defined, use the round-robin rule of REQ-017.

Verification
REQ-031 SHALL cover single request: req=0001, addr0=0x05A, sel0=3 -> gnt=0001, sprt_addr=0x05A and sprt_s=3 after the edge, rsp_valid=1 with rsp_id=0 two edges after accept, rsp_data=rom_data.
REQ-032 SHALL cover round-robin: req=1111 held for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order 2 cycles later.
REQ-033 SHALL cover invalid code: req=0100, sel2=15 -> rsp_valid=1, rsp_id=2, rsp_data=0, rsp_err=1.
REQ-034 SHALL cover reset mid-operation: Reset pulsed one cycle after an accept -> no rsp_valid afterwards, all outputs 0, and the next req=1010 grants requester 1 first.
REQ-035 SHALL cover SPRITE_ARB_FIXED_PRIO_EN defined with req=0110 held -> gnt=0010 on every cycle.
